// File: rtl/quad_byte_serializer.sv
// -----------------------------------------------------------------------------
// quad_byte_serializer
//
// Captures four parallel WIDTH-bit words into a shadow bank on an accepted
// start request and shifts them out one bit per clock as a single frame
// (in1 first, in4 last), with a valid strobe, a start-of-frame marker on the
// first bit and a one-cycle completion pulse.
//
// Parameters:
//   WIDTH     : bits per word, 2..32
//   MSB_FIRST : 1 = each word sent MSB first, 0 = LSB first
//
// Build option:
//   QBS_PARITY_EN : when defined, each word is followed by an even-parity bit
//                   (XOR of the word), sent with sval=1.
//
// Ports:
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   in1..in4        : parallel words, sampled only when start is accepted
//   start           : frame request, honoured only in IDLE
//   busy            : frame in progress (through the done cycle)
//   sdata           : serial data bit (0 whenever sval=0)
//   sval            : sdata valid
//   sof             : first bit of in1
//   done            : one-cycle pulse after the last bit
//
// All outputs are registered decodes of the FSM state and counters, so each
// output trails the state it describes by one clock.
// -----------------------------------------------------------------------------
module quad_byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic             start,
  output logic             busy,
  output logic             sdata,
  output logic             sval,
  output logic             sof,
  output logic             done
);

`ifdef QBS_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Bit counter is sized for 0..WIDTH so the parity slot fits when enabled.
  localparam int                BIT_W     = $clog2(WIDTH + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1 + PAR_BITS);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_shadow [4];
  logic [1:0]       r_byte_idx;
  logic [BIT_W-1:0] r_bit_idx;

  logic             r_busy;
  logic             r_sdata;
  logic             r_sval;
  logic             r_sof;
  logic             r_done;

  logic             w_last_bit;
  logic             w_last_byte;
  logic [WIDTH-1:0] w_cur_word;
  logic [BIT_W-1:0] w_sel_idx;
  logic [WIDTH-1:0] w_shifted;
  logic             w_bit;

  logic             w_busy_nx;
  logic             w_sdata_nx;
  logic             w_sval_nx;
  logic             w_sof_nx;
  logic             w_done_nx;

  // ---------------------------------------------------------------------------
  // Bit selection from the shadow word currently being sent
  // ---------------------------------------------------------------------------
  assign w_last_bit  = (r_bit_idx == LAST_BIT);
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_cur_word  = r_shadow[r_byte_idx];

  // Shift-and-take-LSB avoids a variable part-select whose index width would
  // not match the word width.
  assign w_sel_idx   = MSB_FIRST ? (LAST_DATA - r_bit_idx) : r_bit_idx;
  assign w_shifted   = w_cur_word >> w_sel_idx;

`ifdef QBS_PARITY_EN
  // The slot after the last data bit carries the even-parity bit.
  assign w_bit = (r_bit_idx == BIT_W'(WIDTH)) ? ^w_cur_word : w_shifted[0];
`else
  assign w_bit = w_shifted[0];
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next_state = start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_next_state = (w_last_bit && w_last_byte) ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy_nx  = 1'b0;
    w_sdata_nx = 1'b0;
    w_sval_nx  = 1'b0;
    w_sof_nx   = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Accepting start raises busy on the very next cycle.
        w_busy_nx = start;
      end
      ST_SHIFT: begin
        w_busy_nx  = 1'b1;
        w_sval_nx  = 1'b1;
        w_sdata_nx = w_bit;
        w_sof_nx   = (r_byte_idx == 2'd0) && (r_bit_idx == '0);
      end
      ST_DONE: begin
        w_busy_nx = 1'b1;
        w_done_nx = 1'b1;
      end
      default: begin
        w_busy_nx = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shadow bank and bit/byte counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow bank is cleared on reset so an aborted frame leaves
      // no stale words behind; it is only four words, so the reset is cheap.
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= '0;
      end
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shadow[0] <= in1;
            r_shadow[1] <= in2;
            r_shadow[2] <= in3;
            r_shadow[3] <= in4;
            r_byte_idx  <= '0;
            r_bit_idx   <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_last_bit) begin
            r_bit_idx  <= '0;
            r_byte_idx <= r_byte_idx + 2'd1;
          end else begin
            r_bit_idx  <= r_bit_idx + BIT_W'(1);
          end
        end
        default: begin
          r_bit_idx  <= r_bit_idx;
          r_byte_idx <= r_byte_idx;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_sdata <= 1'b0;
      r_sval  <= 1'b0;
      r_sof   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy  <= w_busy_nx;
      r_sdata <= w_sdata_nx;
      r_sval  <= w_sval_nx;
      r_sof   <= w_sof_nx;
      r_done  <= w_done_nx;
    end
  end

  assign busy  = r_busy;
  assign sdata = r_sdata;
  assign sval  = r_sval;
  assign sof   = r_sof;
  assign done  = r_done;

endmodule

// File: tb/tb_quad_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_quad_byte_serializer
//
// Drives two serializers (MSB-first and LSB-first, WIDTH=8) from the same
// inputs and compares their per-cycle outputs against a frame timeline built
// from the word values: bit j of the serial stream, sval/sof/done/busy per
// cycle, for one frame or several back-to-back frames.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_quad_byte_serializer;

  localparam int W = 8;
`ifdef QBS_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = 4 * (W + PAR);  // sval cycles per frame
  localparam int P = L + 2;          // frame period with start held high

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in1, in2, in3, in4;
  logic         start;

  logic busy_m, sdata_m, sval_m, sof_m, done_m;
  logic busy_l, sdata_l, sval_l, sof_l, done_l;

  quad_byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .start(start),
    .busy(busy_m), .sdata(sdata_m), .sval(sval_m), .sof(sof_m), .done(done_m)
  );

  quad_byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .start(start),
    .busy(busy_l), .sdata(sdata_l), .sval(sval_l), .sof(sof_l), .done(done_l)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Serial stream of one frame: bit j is the j-th bit on the wire.
  function automatic logic [63:0] serial_bits(input logic [W-1:0] w0, w1, w2, w3,
                                              input bit msb);
    logic [W-1:0] w [4];
    logic [63:0]  v;
    int           j;
    w = '{w0, w1, w2, w3};
    v = '0;
    j = 0;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < W; b++) begin
        v[j] = msb ? w[i][W-1-b] : w[i][b];
        j++;
      end
      if (PAR == 1) begin
        v[j] = ^w[i];
        j++;
      end
    end
    return v;
  endfunction

  // Start nframes frames (start held high across them), optionally zero the
  // inputs right after capture, optionally pulse start mid-frame, and compare
  // every output cycle from the first bit to the idle cycle after the last done.
  task automatic run_frames(input logic [W-1:0] a, b, c, d, input int nframes,
                            input bit scramble, input bit mid_start,
                            input string tag);
    logic [63:0]  bm, bl;
    logic [127:0] e_sval, e_sof, e_done, e_busy, e_dm, e_dl;
    logic [127:0] g_sval, g_sof, g_done, g_busy, g_dm, g_dl, g_svl;
    int           ncyc;
    int           base;
    bm   = serial_bits(a, b, c, d, 1'b1);
    bl   = serial_bits(a, b, c, d, 1'b0);
    ncyc = nframes * P;
    {e_sval, e_sof, e_done, e_busy, e_dm, e_dl} = '0;
    {g_sval, g_sof, g_done, g_busy, g_dm, g_dl, g_svl} = '0;
    for (int f = 0; f < nframes; f++) begin
      base = f * P;
      for (int k = 0; k < L; k++) begin
        e_sval[base+k] = 1'b1;
        e_busy[base+k] = 1'b1;
        e_dm[base+k]   = bm[k];
        e_dl[base+k]   = bl[k];
      end
      e_sof[base]      = 1'b1;
      e_done[base+L]   = 1'b1;
      e_busy[base+L]   = 1'b1;
      e_busy[base+L+1] = (f < nframes - 1);
    end

    @(negedge clk);
    in1 = a; in2 = b; in3 = c; in4 = d;
    start = 1'b1;
    @(negedge clk);  // start has been sampled at the edge just passed
    if (nframes == 1) start = 1'b0;
    if (scramble) begin
      in1 = '0; in2 = '0; in3 = '0; in4 = '0;
    end
    check({tag, ".accept"}, {124'd0, busy_m, sval_m, busy_l, sval_l}, 128'b1010);

    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      g_sval[k] = sval_m;
      g_sof[k]  = sof_m;
      g_done[k] = done_m;
      g_busy[k] = busy_m;
      g_dm[k]   = sdata_m;
      g_dl[k]   = sdata_l;
      g_svl[k]  = sval_l;
      if (nframes > 1 && k == (nframes - 1) * P + 3) start = 1'b0;
      if (mid_start && k == 5) start = 1'b1;
      if (mid_start && k == 6) start = 1'b0;
    end

    check({tag, ".sval"},      g_sval, e_sval);
    check({tag, ".sof"},       g_sof,  e_sof);
    check({tag, ".done"},      g_done, e_done);
    check({tag, ".busy"},      g_busy, e_busy);
    check({tag, ".sdata_msb"}, g_dm,   e_dm);
    check({tag, ".sdata_lsb"}, g_dl,   e_dl);
    check({tag, ".sval_lsb"},  g_svl,  e_sval);

    // No extra frame may follow (a mid-frame start must not be queued).
    repeat (3) @(negedge clk);
    check({tag, ".quiet"}, {123'd0, busy_m, sval_m, done_m, busy_l, sval_l}, 128'd0);
  endtask

  task automatic reset_mid_frame();
    @(negedge clk);
    in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom); in4 = W'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);  // now showing bit 13
    check("rst.mid_frame_active", {127'd0, sval_m}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.async_outputs",
          {118'd0, busy_m, sdata_m, sval_m, sof_m, done_m,
                   busy_l, sdata_l, sval_l, sof_l, done_l}, 128'd0);
    repeat (2) @(negedge clk);
    check("rst.held_outputs",
          {118'd0, busy_m, sdata_m, sval_m, sof_m, done_m,
                   busy_l, sdata_l, sval_l, sof_l, done_l}, 128'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;  // next rising edge is the first one out of reset
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0;
    #3;
    check("reset.outputs",
          {118'd0, busy_m, sdata_m, sval_m, sof_m, done_m,
                   busy_l, sdata_l, sval_l, sof_l, done_l}, 128'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic frame with inputs zeroed right after capture.
    run_frames(8'hA5, 8'h3C, 8'h0F, 8'hF0, 1, 1'b1, 1'b0, "basic");
    // LSB-first stream of 01 starts with 1 then seven 0s; start pulsed mid-frame.
    run_frames(8'h01, 8'h80, 8'h7E, 8'h55, 1, 1'b0, 1'b1, "lsb_mid_start");
    // Parity vector (parity bits 1,0,0,1 when enabled).
    run_frames(8'h07, 8'h03, 8'hFF, 8'h80, 1, 1'b0, 1'b0, "parity_vec");
    // Three back-to-back frames with start held high.
    run_frames(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
               3, 1'b0, 1'b0, "b2b");

    for (int i = 0; i < 6; i++) begin
      run_frames(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                 1, 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    reset_mid_frame();
    run_frames(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
               1, 1'b0, 1'b0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_byte_serializer.md
# quad_byte_serializer

Transmit-side block that takes four parallel WIDTH-bit words (`in1`..`in4`) and shifts them out as a single-bit serial frame with a valid strobe, start-of-frame marker and completion pulse. It is the producer counterpart to a four-output parallel capture block: words presented in parallel are emitted one bit per clock. It is used in the simple-design regression set as a self-contained sequencer with a small FSM, bit and byte counters, and a shadow register bank.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = each word is sent MSB first; 0 = LSB first.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in1`, `in2`, `in3`, `in4`  input  WIDTH each  parallel words; sent in order in1, in2, in3, in4.
- `start`  input  1  frame request; sampled only in IDLE.
- `busy`  output  1  high from the cycle after start is accepted through the DONE cycle.
- `sdata`  output  1  serial data bit.
- `sval`  output  1  sdata is valid this cycle.
- `sof`  output  1  high with the first bit of in1 only.
- `done`  output  1  one-cycle pulse after the last bit.

## Operation
- FSM states: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE: if `start`=1 at a rising edge, capture in1..in4 into a shadow bank, clear byte index (0..3) and bit index, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each cycle drive `sval`=1 and `sdata` = the current bit of shadow word[byte index]. Bit order follows MSB_FIRST.
  - Bit index counts 0..WIDTH-1, or 0..WIDTH with parity enabled.
  - At terminal bit count: clear bit index and increment byte index.
  - At terminal bit of byte 3: go to DONE.
- DONE: `done`=1 and `busy`=1 for one cycle, `sval`=0, then go to IDLE.
- `start` in SHIFT or DONE is ignored; it is not queued.
- Changes on in1..in4 after capture have no effect on the frame in flight.
- When `sval`=0, `sdata`=0.
- Outputs are registered, with no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous, any state, mid-frame included): state IDLE, all counters and the shadow bank cleared. `busy`, `sdata`, `sval`, `sof` and `done` are all 0 immediately.
- Reset release: the first rising edge with `rst_n`=1 can accept `start`.
- Latency: `start` sampled at edge N gives the first bit (`sval`=`sof`=1) after edge N+1.
- Frame length: 4·WIDTH cycles of `sval`, or 4·(WIDTH+1) with parity. `sval` is continuous, with no gaps between words.
- `done` is asserted the cycle after the last `sval` cycle.
- With `start` held high, frames repeat with exactly 2 cycles of `sval`=0 between them (the DONE and IDLE cycles).

## Configuration
- `QBS_PARITY_EN` defined: after each word's WIDTH data bits, one extra bit is sent with `sval`=1. It is the even-parity bit, equal to the XOR of that word. The bit counter is widened to count 0..WIDTH.
- `QBS_PARITY_EN` undefined: no parity bit is sent and the frame is 4·WIDTH bits.

## Test plan
- Basic frame: WIDTH=8, MSB_FIRST=1, in1..in4 = A5, 3C, 0F, F0, `start` pulsed once.
  - First 8 bits are 1,0,1,0,0,1,0,1, with `sof` on bit 0 only.
  - 32 contiguous `sval` cycles.
  - `done` on the 33rd cycle after the first bit; `busy` falls the cycle after.
- LSB order: MSB_FIRST=0, in1=01 → first bit 1, followed by seven 0s.
- Input isolation: change in1..in4 to 00 on the cycle after `start` → the serial stream still carries A5, 3C, 0F, F0.
- Back-to-back and ignored start: hold `start` high for 3 frames.
  - Exactly 2 `sval`=0 cycles separate frames.
  - A `start` pulse mid-frame causes no extra frame.
- Reset mid-frame: deassert `rst_n` at bit 13 → all outputs 0 in the same cycle, without waiting for a clock edge. After release, a new `start` produces a full, correct frame from in1 bit 0.
- Parity (`QBS_PARITY_EN` defined): in1..in4 = 07, 03, FF, 80 → parity bits 1, 0, 0, 1; 36 `sval` cycles; `done` after the 36th bit.
